stopwatch_lap_controller: RTL
=============================

# stopwatch_lap_controller

Parametrised next-generation stopwatch controller. Owns a BCD mm:ss.cc time base driven from `clk_core`, and takes single-cycle button pulses from the debouncer layer. Adds a lap memory of configurable depth with frozen-display lap capture and a lap-browse mode. Outputs feed the display mux directly, replacing the fixed two-button pause/record controller.

## Interface
- `TICK_DIV`, 500000: `clk_core` cycles per 10 ms tick; must be ≥ 2.
- `LAP_DEPTH`, 8: number of stored laps; must be ≥ 2.
- `clk_core` in 1: core clock.
- `rst` in 1: reset, synchronous, active-high.
- `start_stop_p` in 1: one-cycle pulse; run/pause toggle.
- `lap_p` in 1: one-cycle pulse; capture lap.
- `view_p` in 1: one-cycle pulse; live view / browse step.
- `clear_p` in 1: one-cycle pulse; zero time and laps.
- `min_o` out 8: displayed minutes, two BCD digits, 00–99.
- `sec_o` out 8: displayed seconds, BCD, 00–59.
- `ms_10_o` out 8: displayed centiseconds, BCD, 00–99.
- `state_o` out 3: current FSM state encoding.
- `lap_cnt_o` out $clog2(LAP_DEPTH)+1: number of laps stored, saturating at LAP_DEPTH.
- `lap_idx_o` out $clog2(LAP_DEPTH): lap being browsed, where 0 is the oldest stored lap.
- `ovf_o` out 1: sticky flag, set when time wraps past 99:59.99.

## Operation
- States: STOP=0, RUN=1, FREEZE=2, PAUSE=3, BROWSE=4.
- Events: at most one event acts per cycle. Priority is clear > start_stop > lap > view. Lower-priority pulses in the same cycle are dropped.
- Time base:
  - Runs only in RUN and FREEZE.
  - A divider counts 0..TICK_DIV-1. Its terminal count produces a one-cycle tick.
  - The divider holds its value outside RUN/FREEZE.
  - Each tick advances centiseconds. 99 carries into seconds; 59 carries into minutes.
  - 99:59.99 wraps to 00:00.00 and sets `ovf_o`.
- Transitions:
  - STOP:
    - start_stop → RUN.
    - Others are ignored, except clear, which re-zeroes.
  - RUN (display shows live time):
    - start_stop → PAUSE.
    - lap → store the current time and go to FREEZE.
    - view: ignored.
  - FREEZE (counting continues; display holds the last capture):
    - lap → store a new lap; display shows that capture.
    - view → RUN.
    - start_stop → PAUSE, and display switches to live time.
  - PAUSE (display shows held time):
    - start_stop → RUN.
    - clear → STOP.
    - view → BROWSE only if lap_cnt>0, with lap_idx=lap_cnt-1 (newest).
  - BROWSE (display shows lap[lap_idx]):
    - view → lap_idx-1, wrapping from 0 to lap_cnt-1.
    - start_stop → PAUSE.
    - clear → STOP.
    - lap: ignored.
- Clear acts only in STOP/PAUSE/BROWSE; it is ignored in RUN/FREEZE. Clear does all of the following:
  - zeroes time and the divider;
  - sets lap_cnt=0 and lap_idx=0;
  - clears `ovf_o`;
  - moves to STOP.
- Lap memory:
  - Circular; a write pointer points at the oldest slot.
  - When full, a new lap overwrites the oldest entry and lap_cnt stays at LAP_DEPTH.
  - Browse index is logical: index 0 is the oldest entry, not the physical slot.
- Lap coincident with a tick: the stored value is the pre-increment time, i.e. the register value in that cycle.

## Timing
- Reset values:
  - min_o, sec_o, ms_10_o = 0x00;
  - state_o = STOP;
  - lap_cnt_o = 0, lap_idx_o = 0;
  - ovf_o = 0;
  - divider = 0; lap memory contents don't-care.
- Outputs are registered. An event in cycle N is visible on outputs in cycle N+1.
- A tick in cycle N updates the live time, and the display in RUN, in cycle N+1.
- The first tick after STOP→RUN arrives TICK_DIV cycles after the start_stop pulse.
- Reset asserted mid-run takes priority over all pulses in the same cycle.

## Structure
- `stopwatch_pkg` holds:
  - the state enum;
  - BCD limit constants (CC_MAX=8'h99, SS_MAX=8'h59, MM_MAX=8'h99);
  - a packed struct `bcd_time_t` of {min, sec, cc}.
- Sub-module `bcd_time_counter`: enable, tick, clear, time output, and wrap pulse. The divider stays in the top.
- The top holds the FSM, the lap register array, pointers, and the display mux.

## Test plan
- Reset, then start_stop, then 150 ticks (TICK_DIV=2, i.e. 300 cycles) → display 00:01.50, state RUN.
- RUN to 00:00.10, lap, then 5 more ticks → display holds 00:00.10 while state is FREEZE. Then view → display 00:00.15 next cycle.
- LAP_DEPTH=4: take 6 laps at 00:00.01 through 00:00.06, pause, then 4 views → lap_cnt=4 and displayed laps are .06, .05, .04, .03. A 5th view wraps to .06.
- Preload 99:59.98 and run 2 ticks → display 00:00.00 and ovf_o=1. Then pause and clear → ovf_o=0, state STOP.
- start_stop+lap+clear pulsed together in RUN: start_stop wins → PAUSE, no lap stored. In PAUSE, clear+start_stop together → STOP, display 00:00.00.
- Lap pulse in the same cycle as a tick at 00:00.41 → stored lap reads 00:00.41 and live time reads 00:00.42.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch lap controller.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FREEZE = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_BROWSE = 3'd4
  } sw_state_e;

  localparam logic [7:0] CC_MAX = 8'h99;
  localparam logic [7:0] SS_MAX = 8'h59;
  localparam logic [7:0] MM_MAX = 8'h99;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cc;
  } bcd_time_t;

  // Two-digit BCD increment; callers handle the terminal value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// mm:ss.cc BCD counter advanced by an external tick; exposes its next value
// so the display register can follow the live time without a cycle of lag.
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  logic      tick_i,
  input  logic      clr_i,
  output bcd_time_t time_o,
  output bcd_time_t time_nxt_c,
  output logic      wrap_c
);

  bcd_time_t time_q;
  bcd_time_t time_d;

  assign wrap_c = en_i && tick_i && (time_q.cc == CC_MAX) &&
                  (time_q.sec == SS_MAX) && (time_q.min == MM_MAX);

  always_comb begin
    time_d = time_q;
    if (clr_i) begin
      time_d = '0;
    end else if (en_i && tick_i) begin
      if (time_q.cc != CC_MAX) begin
        time_d.cc = bcd_inc(time_q.cc);
      end else begin
        time_d.cc = '0;
        if (time_q.sec != SS_MAX) begin
          time_d.sec = bcd_inc(time_q.sec);
        end else begin
          time_d.sec = '0;
          time_d.min = (time_q.min != MM_MAX) ? bcd_inc(time_q.min) : 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) time_q <= '0;
    else     time_q <= time_d;
  end

  assign time_o     = time_q;
  assign time_nxt_c = time_d;

endmodule

// File: rtl/stopwatch_lap_controller.sv
// Stopwatch FSM with tick divider, circular lap memory and registered
// display mux (live time, frozen capture, or browsed lap).
module stopwatch_lap_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned LAP_DEPTH = 8
) (
  input  logic                         clk_core,
  input  logic                         rst,
  input  logic                         start_stop_p,
  input  logic                         lap_p,
  input  logic                         view_p,
  input  logic                         clear_p,
  output logic [7:0]                   min_o,
  output logic [7:0]                   sec_o,
  output logic [7:0]                   ms_10_o,
  output logic [2:0]                   state_o,
  output logic [$clog2(LAP_DEPTH):0]   lap_cnt_o,
  output logic [$clog2(LAP_DEPTH)-1:0] lap_idx_o,
  output logic                         ovf_o
);

  localparam int unsigned IDX_W = $clog2(LAP_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  sw_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             ovf_q, ovf_d;
  bcd_time_t        disp_q, disp_d;
  bcd_time_t        lap_mem_q [LAP_DEPTH];

  bcd_time_t        live_time;
  bcd_time_t        live_nxt;
  logic             wrap;
  logic             running;
  logic             tick;
  logic             clr_act;
  logic             lap_we;
  logic [SUM_W-1:0] slot_sum;
  logic [IDX_W-1:0] rd_slot;

  assign running = (state_q == ST_RUN) || (state_q == ST_FREEZE);
  assign tick    = running && (div_q == DIV_W'(TICK_DIV - 1));

  bcd_time_counter u_time (
    .clk        (clk_core),
    .rst        (rst),
    .en_i       (running),
    .tick_i     (tick),
    .clr_i      (clr_act),
    .time_o     (live_time),
    .time_nxt_c (live_nxt),
    .wrap_c     (wrap)
  );

  // Divider: counts only while the time base runs, zeroed by clear.
  always_comb begin
    div_d = div_q;
    if (clr_act)      div_d = '0;
    else if (tick)    div_d = '0;
    else if (running) div_d = div_q + DIV_W'(1);
  end

  // Event priority is resolved per state so ignored events never mask others.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q | wrap;
    clr_act  = 1'b0;
    lap_we   = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        if (clear_p)           clr_act = 1'b1;
        else if (start_stop_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop_p) state_d = ST_PAUSE;
        else if (lap_p) begin
          lap_we  = 1'b1;
          state_d = ST_FREEZE;
        end
      end
      ST_FREEZE: begin
        if (start_stop_p) state_d = ST_PAUSE;
        else if (lap_p)   lap_we  = 1'b1;
        else if (view_p)  state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (clear_p)           clr_act = 1'b1;
        else if (start_stop_p) state_d = ST_RUN;
        else if (view_p && (cnt_q != '0)) begin
          state_d = ST_BROWSE;
          idx_d   = IDX_W'(cnt_q - CNT_W'(1));
        end
      end
      ST_BROWSE: begin
        if (clear_p)           clr_act = 1'b1;
        else if (start_stop_p) state_d = ST_PAUSE;
        else if (view_p) begin
          idx_d = (idx_q == '0) ? IDX_W'(cnt_q - CNT_W'(1)) : idx_q - IDX_W'(1);
        end
      end
      default: state_d = ST_STOP;
    endcase

    if (lap_we) begin
      wr_ptr_d = (wr_ptr_q == IDX_W'(LAP_DEPTH - 1)) ? '0 : wr_ptr_q + IDX_W'(1);
      if (cnt_q != CNT_W'(LAP_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end

    if (clr_act) begin
      state_d  = ST_STOP;
      cnt_d    = '0;
      idx_d    = '0;
      wr_ptr_d = '0;
      ovf_d    = 1'b0;
    end
  end

  // Logical browse index -> physical slot, oldest entry at (wr_ptr - cnt).
  always_comb begin
    slot_sum = SUM_W'(wr_ptr_q) + SUM_W'(idx_d) + SUM_W'(LAP_DEPTH) - SUM_W'(cnt_q);
    if (slot_sum >= SUM_W'(2 * LAP_DEPTH))  slot_sum = slot_sum - SUM_W'(2 * LAP_DEPTH);
    else if (slot_sum >= SUM_W'(LAP_DEPTH)) slot_sum = slot_sum - SUM_W'(LAP_DEPTH);
    rd_slot = IDX_W'(slot_sum);
  end

  always_comb begin
    disp_d = disp_q;
    unique case (state_d)
      ST_FREEZE: if (lap_we) disp_d = live_time;
      ST_BROWSE: disp_d = lap_mem_q[rd_slot];
      default:   disp_d = live_nxt;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q  <= ST_STOP;
      div_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
      disp_q   <= disp_d;
    end
  end

  // Lap storage holds the pre-increment time of the capture cycle.
  always_ff @(posedge clk_core) begin
    if (lap_we) lap_mem_q[wr_ptr_q] <= live_time;
  end

  assign min_o     = disp_q.min;
  assign sec_o     = disp_q.sec;
  assign ms_10_o   = disp_q.cc;
  assign state_o   = state_q;
  assign lap_cnt_o = cnt_q;
  assign lap_idx_o = idx_q;
  assign ovf_o     = ovf_q;

endmodule
